// File: rtl/segasys1_main_io.sv
// Main-CPU I/O block: port/DIP read mux, video-mode latch, sound-command FIFO, VBLANK IRQ.
// Latency: reads are combinational; writes commit on the first CLK48M edge of a strobe and are visible the cycle after.
// Backpressure: none toward the CPU; a push into a full FIFO is dropped and flagged on SNDOVF.
//
// Ports:
//   CLK48M, RESET          system clock, asynchronous active-high reset
//   CPUAD/CPUDO            Z80 low address byte / write data
//   CPUIORQ/CPURD/CPUWR/CPUM1  Z80 bus strobes, active-high
//   INP                    NPORT packed input ports, port k = INP[8k+7:8k]
//   VBLK                   vertical blank (CLK48M domain)
//   SNDACK                 sound CPU pop request, rising edge pops the head
//   IODV/IODO              I/O read data valid / data
//   VIDMD                  video mode latch
//   INTREQ                 main-CPU interrupt request
//   SNDRQ/SNDNO/SNDCNT     FIFO not-empty / head entry / occupancy
//   SNDPULSE/SNDOVF        one-cycle accepted-push pulse / sticky overflow flag
module segasys1_main_io #(
  parameter int          NPORT    = 5,
  parameter int          FAW      = 2,
  parameter int          IRQ_MODE = 1,
  parameter logic [7:0]  SNDA0    = 8'h14,
  parameter logic [7:0]  SNDA1    = 8'h18,
  parameter logic [7:0]  VIDA0    = 8'h15,
  parameter logic [7:0]  VIDA1    = 8'h19
) (
  input  logic               CLK48M,
  input  logic               RESET,
  input  logic [7:0]         CPUAD,
  input  logic [7:0]         CPUDO,
  input  logic               CPUIORQ,
  input  logic               CPURD,
  input  logic               CPUWR,
  input  logic               CPUM1,
  input  logic [8*NPORT-1:0] INP,
  input  logic               VBLK,
  input  logic               SNDACK,
  output logic               IODV,
  output logic [7:0]         IODO,
  output logic [7:0]         VIDMD,
  output logic               INTREQ,
  output logic               SNDRQ,
  output logic [7:0]         SNDNO,
  output logic [FAW:0]       SNDCNT,
  output logic               SNDPULSE,
  output logic               SNDOVF
);

  localparam int DEPTH = 1 << FAW;
  localparam logic [FAW:0] DEPTH_CNT = DEPTH[FAW:0];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       w_io;
  logic       w_snd_hit;
  logic       w_vid_hit;
  logic [2:0] w_port_idx;
  logic       w_port_hit;
  logic [7:0] w_port_dat;

  assign w_io       = CPUIORQ & ~CPUM1;
  assign w_snd_hit  = w_io & ((CPUAD == SNDA0) | (CPUAD == SNDA1));
  assign w_vid_hit  = w_io & ((CPUAD == VIDA0) | (CPUAD == VIDA1));
  assign w_port_idx = CPUAD[4:2];
  // Sound/video addresses overlap the port decode range, so they mask it.
  assign w_port_hit = w_io & ({1'b0, w_port_idx} < 4'(NPORT)) & ~w_snd_hit & ~w_vid_hit;

  // Loop mux keeps the select in range for any NPORT.
  always_comb begin
    w_port_dat = 8'hFF;
    for (int k = 0; k < NPORT; k++) begin
      if (w_port_idx == 3'(k)) begin
        w_port_dat = INP[8*k +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path (purely combinational)
  // ---------------------------------------------------------------------------
  logic [7:0] r_vidmd;

  always_comb begin
    IODV = 1'b0;
    IODO = 8'hFF;
    if (CPURD) begin
      if (w_vid_hit) begin
        IODV = 1'b1;
        IODO = r_vidmd;
      end else if (w_port_hit) begin
        IODV = 1'b1;
        IODO = w_port_dat;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write strobe: a Z80 OUT spans many CLK48M cycles, commit only on its first edge
  // ---------------------------------------------------------------------------
  logic w_strobe;
  logic w_commit;
  logic r_s_prev;

  assign w_strobe = CPUIORQ & CPUWR & ~CPUM1 & (w_snd_hit | w_vid_hit);
  assign w_commit = w_strobe & ~r_s_prev;

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      r_s_prev <= 1'b0;
      r_vidmd  <= 8'h00;
    end else begin
      r_s_prev <= w_strobe;
      if (w_commit & w_vid_hit) begin
        r_vidmd <= CPUDO;
      end
    end
  end

  assign VIDMD = r_vidmd;

  // ---------------------------------------------------------------------------
  // Sound-command FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]     r_mem [DEPTH];
  logic [FAW-1:0] r_wp;
  logic [FAW-1:0] r_rp;
  logic [FAW:0]   r_cnt;
  logic           r_pulse;
  logic           r_ovf;
  logic           r_ack_d1;
  logic           r_ack_d2;

  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_ovf;

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == DEPTH_CNT);
  assign w_push_req = w_commit & w_snd_hit;
  // SNDACK edge is taken from the registered history, so a pop lands two edges after SNDACK rises.
  assign w_pop      = r_ack_d1 & ~r_ack_d2 & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf      = w_push_req & w_full & ~w_pop;

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
      r_ovf    <= 1'b0;
      r_ack_d1 <= 1'b0;
      r_ack_d2 <= 1'b0;
    end else begin
      r_ack_d1 <= SNDACK;
      r_ack_d2 <= r_ack_d1;
      r_pulse  <= w_push;
      if (w_push) begin
        r_mem[r_wp] <= CPUDO;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_push & ~w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (~w_push & w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign SNDRQ    = ~w_empty;
  assign SNDNO    = w_empty ? 8'h00 : r_mem[r_rp];
  assign SNDCNT   = r_cnt;
  assign SNDPULSE = r_pulse;
  assign SNDOVF   = r_ovf;

  // ---------------------------------------------------------------------------
  // VBLANK interrupt
  // ---------------------------------------------------------------------------
  logic r_vblk_prev;
  logic r_iack_prev;
  logic r_int;
  logic w_vblk_rise;
  logic w_iack_src;
  logic w_iack;

  assign w_vblk_rise = VBLK & ~r_vblk_prev;
  assign w_iack_src  = CPUM1 & CPUIORQ;
  assign w_iack      = w_iack_src & ~r_iack_prev;

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      r_vblk_prev <= 1'b0;
      r_iack_prev <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      r_vblk_prev <= VBLK;
      r_iack_prev <= w_iack_src;
      if (IRQ_MODE == 0) begin
        r_int <= VBLK;
      end else if (w_vblk_rise) begin
        // A new VBLANK edge beats a coincident acknowledge so no frame is lost.
        r_int <= 1'b1;
      end else if (w_iack) begin
        r_int <= 1'b0;
      end
    end
  end

  assign INTREQ = r_int;

endmodule

// File: tb/tb_segasys1_main_io.sv
// Bench for segasys1_main_io: read-decode vector table plus directed video, FIFO and IRQ sequences.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: none; all waits are fixed cycle counts under a global watchdog.
module tb_segasys1_main_io;

  localparam int NPORT = 5;
  localparam int FAW   = 2;

  logic               CLK48M;
  logic               RESET;
  logic [7:0]         CPUAD;
  logic [7:0]         CPUDO;
  logic               CPUIORQ;
  logic               CPURD;
  logic               CPUWR;
  logic               CPUM1;
  logic [8*NPORT-1:0] INP;
  logic               VBLK;
  logic               SNDACK;
  logic               IODV;
  logic [7:0]         IODO;
  logic [7:0]         VIDMD;
  logic               INTREQ;
  logic               SNDRQ;
  logic [7:0]         SNDNO;
  logic [FAW:0]       SNDCNT;
  logic               SNDPULSE;
  logic               SNDOVF;

  segasys1_main_io #(
    .NPORT(NPORT), .FAW(FAW), .IRQ_MODE(1),
    .SNDA0(8'h14), .SNDA1(8'h18), .VIDA0(8'h15), .VIDA1(8'h19)
  ) dut (
    .CLK48M(CLK48M), .RESET(RESET), .CPUAD(CPUAD), .CPUDO(CPUDO),
    .CPUIORQ(CPUIORQ), .CPURD(CPURD), .CPUWR(CPUWR), .CPUM1(CPUM1),
    .INP(INP), .VBLK(VBLK), .SNDACK(SNDACK),
    .IODV(IODV), .IODO(IODO), .VIDMD(VIDMD), .INTREQ(INTREQ),
    .SNDRQ(SNDRQ), .SNDNO(SNDNO), .SNDCNT(SNDCNT), .SNDPULSE(SNDPULSE), .SNDOVF(SNDOVF)
  );

  initial CLK48M = 1'b0;
  always #5 CLK48M = ~CLK48M;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] ad;
    logic       iorq;
    logic       rd;
    logic       m1;
    logic       exp_dv;
    logic [7:0] exp_do;
  } rd_vec_t;

  task automatic tick();
    @(posedge CLK48M);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK48M);
    #1 RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  // Holds an OUT strobe for ncyc cycles and counts SNDPULSE cycles seen meanwhile.
  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int ncyc, output int pulses);
    pulses = 0;
    tick();
    CPUAD = a; CPUDO = d; CPUIORQ = 1'b1; CPUWR = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge CLK48M);
      if (SNDPULSE) pulses++;
    end
    tick();
    CPUIORQ = 1'b0; CPUWR = 1'b0;
    repeat (2) begin
      @(negedge CLK48M);
      if (SNDPULSE) pulses++;
    end
  endtask

  task automatic ack_pulse();
    tick();
    SNDACK = 1'b1;
    repeat (3) tick();
    SNDACK = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_vec_t vecs[13];
    int      p;
    logic [7:0] drain_exp [4];

    vecs[0]  = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10};
    vecs[1]  = '{8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11};
    vecs[2]  = '{8'h08, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12};
    vecs[3]  = '{8'h0C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13};
    vecs[4]  = '{8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14};
    vecs[5]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[6]  = '{8'h14, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[7]  = '{8'h18, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[8]  = '{8'h15, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[9]  = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[10] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF};
    vecs[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF};
    vecs[12] = '{8'h13, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14};

    RESET = 1'b1; CPUAD = 8'h00; CPUDO = 8'h00; CPUIORQ = 1'b0; CPURD = 1'b0;
    CPUWR = 1'b0; CPUM1 = 1'b0; VBLK = 1'b0; SNDACK = 1'b0;
    INP = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    repeat (3) @(posedge CLK48M);
    #1 RESET = 1'b0;
    @(negedge CLK48M);

    // Reset state
    chk("rst_vidmd", 32'(VIDMD), 32'h00);
    chk("rst_intreq", 32'(INTREQ), 32'h0);
    chk("rst_sndrq", 32'(SNDRQ), 32'h0);
    chk("rst_sndno", 32'(SNDNO), 32'h00);
    chk("rst_sndcnt", 32'(SNDCNT), 32'h0);
    chk("rst_sndpulse", 32'(SNDPULSE), 32'h0);
    chk("rst_sndovf", 32'(SNDOVF), 32'h0);

    // Read decode table
    for (int i = 0; i < 13; i++) begin
      tick();
      CPUAD = vecs[i].ad; CPUIORQ = vecs[i].iorq; CPURD = vecs[i].rd; CPUM1 = vecs[i].m1;
      @(negedge CLK48M);
      chk($sformatf("rd_iodv[%0d]", i), 32'(IODV), 32'(vecs[i].exp_dv));
      chk($sformatf("rd_iodo[%0d]", i), 32'(IODO), 32'(vecs[i].exp_do));
    end
    tick();
    CPUIORQ = 1'b0; CPURD = 1'b0; CPUM1 = 1'b0;

    // Video latch: long strobe, single commit, readback through the alias address
    io_write(8'h15, 8'hA5, 40, p);
    chk("vid_vidmd", 32'(VIDMD), 32'hA5);
    chk("vid_no_sndpulse", 32'(p), 32'd0);
    chk("vid_no_push", 32'(SNDCNT), 32'd0);
    tick();
    CPUAD = 8'h19; CPUIORQ = 1'b1; CPURD = 1'b1;
    @(negedge CLK48M);
    chk("vid_rd_iodv", 32'(IODV), 32'h1);
    chk("vid_rd_iodo", 32'(IODO), 32'hA5);
    tick();
    CPUIORQ = 1'b0; CPURD = 1'b0;

    // FIFO fill and overflow
    for (int i = 1; i <= 5; i++) begin
      io_write(8'h14, 8'(i), 6, p);
      chk($sformatf("fill_pulses[%0d]", i), 32'(p), (i <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("fill_cnt[%0d]", i), 32'(SNDCNT), (i <= 4) ? 32'(i) : 32'd4);
      if (i == 4) chk("fill_ovf_before", 32'(SNDOVF), 32'h0);
    end
    chk("fill_ovf", 32'(SNDOVF), 32'h1);
    chk("fill_sndno", 32'(SNDNO), 32'h01);
    chk("fill_sndrq", 32'(SNDRQ), 32'h1);

    // First pop with timing: lands two edges after SNDACK rises
    tick();
    SNDACK = 1'b1;
    @(negedge CLK48M);
    chk("pop_t0_cnt", 32'(SNDCNT), 32'd4);
    @(negedge CLK48M);
    chk("pop_t1_cnt", 32'(SNDCNT), 32'd4);
    @(negedge CLK48M);
    chk("pop_t2_cnt", 32'(SNDCNT), 32'd3);
    chk("pop_t2_sndno", 32'(SNDNO), 32'h02);
    repeat (3) tick();
    chk("pop_held_cnt", 32'(SNDCNT), 32'd3);
    SNDACK = 1'b0;
    repeat (3) tick();

    ack_pulse();
    chk("drain_sndno_2", 32'(SNDNO), 32'h03);
    ack_pulse();
    chk("drain_sndno_3", 32'(SNDNO), 32'h04);
    ack_pulse();
    chk("drain_sndno_4", 32'(SNDNO), 32'h00);
    chk("drain_sndrq", 32'(SNDRQ), 32'h0);
    ack_pulse();
    chk("drain_empty_cnt", 32'(SNDCNT), 32'd0);
    chk("drain_empty_sndno", 32'(SNDNO), 32'h00);
    chk("drain_ovf_sticky", 32'(SNDOVF), 32'h1);

    // Reset clears flags; then simultaneous push and pop on a full FIFO
    do_reset();
    chk("rst2_ovf", 32'(SNDOVF), 32'h0);
    chk("rst2_cnt", 32'(SNDCNT), 32'd0);
    chk("rst2_vidmd", 32'(VIDMD), 32'h00);
    for (int i = 1; i <= 4; i++) io_write(8'h18, 8'(i), 4, p);
    chk("full_cnt", 32'(SNDCNT), 32'd4);
    tick();
    SNDACK = 1'b1;
    tick();
    CPUAD = 8'h14; CPUDO = 8'h55; CPUIORQ = 1'b1; CPUWR = 1'b1;
    @(posedge CLK48M);
    @(negedge CLK48M);
    chk("pp_pulse", 32'(SNDPULSE), 32'h1);
    chk("pp_cnt", 32'(SNDCNT), 32'd4);
    chk("pp_ovf", 32'(SNDOVF), 32'h0);
    chk("pp_sndno", 32'(SNDNO), 32'h02);
    tick();
    CPUIORQ = 1'b0; CPUWR = 1'b0; SNDACK = 1'b0;
    repeat (3) tick();
    drain_exp[0] = 8'h03; drain_exp[1] = 8'h04; drain_exp[2] = 8'h55; drain_exp[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ack_pulse();
      chk($sformatf("pp_drain[%0d]", i), 32'(SNDNO), 32'(drain_exp[i]));
    end

    // IRQ mode 1
    tick();
    VBLK = 1'b1;
    @(negedge CLK48M);
    chk("irq_before_edge", 32'(INTREQ), 32'h0);
    @(negedge CLK48M);
    chk("irq_set", 32'(INTREQ), 32'h1);
    repeat (3) tick();
    VBLK = 1'b0;
    repeat (3) tick();
    chk("irq_held", 32'(INTREQ), 32'h1);
    CPUM1 = 1'b1; CPUIORQ = 1'b1;
    @(negedge CLK48M);
    @(negedge CLK48M);
    chk("irq_ack", 32'(INTREQ), 32'h0);
    tick();
    CPUM1 = 1'b0; CPUIORQ = 1'b0;
    tick();
    VBLK = 1'b1;
    repeat (3) tick();
    VBLK = 1'b0;
    repeat (2) tick();
    chk("irq_reset_pre", 32'(INTREQ), 32'h1);
    VBLK = 1'b1; CPUM1 = 1'b1; CPUIORQ = 1'b1;
    repeat (3) tick();
    @(negedge CLK48M);
    chk("irq_set_wins", 32'(INTREQ), 32'h1);
    tick();
    CPUM1 = 1'b0; CPUIORQ = 1'b0; VBLK = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
